// File: rtl/execute_if.sv
// ============================================================================
// Module   : execute_if
// Purpose  : Decode-to-execute bus and registered E/M result bus.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface execute_if;
    logic [3:0]  icode_i;
    logic [3:0]  ifun_i;
    logic [63:0] valA_i;
    logic [63:0] valB_i;
    logic [63:0] valC_i;
    logic [3:0]  dstE_i;
    logic [3:0]  dstM_i;
    logic        instr_valid_i;
    logic        imem_error_i;
    logic        stall_i;
    logic        bubble_i;
    logic        squash_cc_i;

    logic [3:0]  icode_o;
    logic        cnd_o;
    logic [63:0] valE_o;
    logic [63:0] valA_o;
    logic [3:0]  dstE_o;
    logic [3:0]  dstM_o;
    logic        instr_valid_o;
    logic        imem_error_o;
    logic [2:0]  cc_o;

    modport master (
        output icode_i, ifun_i, valA_i, valB_i, valC_i, dstE_i, dstM_i,
               instr_valid_i, imem_error_i, stall_i, bubble_i, squash_cc_i,
        input  icode_o, cnd_o, valE_o, valA_o, dstE_o, dstM_o,
               instr_valid_o, imem_error_o, cc_o
    );

    modport slave (
        input  icode_i, ifun_i, valA_i, valB_i, valC_i, dstE_i, dstM_i,
               instr_valid_i, imem_error_i, stall_i, bubble_i, squash_cc_i,
        output icode_o, cnd_o, valE_o, valA_o, dstE_o, dstM_o,
               instr_valid_o, imem_error_o, cc_o
    );
endinterface

`default_nettype wire

// File: rtl/execute_stage.sv
// ============================================================================
// Module   : execute_stage
// Purpose  : Y86-64 execute stage: ALU, condition codes, jump/cmov condition,
//            E/M pipeline register with stall/bubble. Optional macro
//            EXEC_CMOV_EN enables conditional-move evaluation on icode 2.
// Revision : 1.0
// ============================================================================
`default_nettype none

module execute_stage #(
    parameter logic [3:0] NOP_ICODE = 4'h1,
    parameter logic [3:0] RNONE     = 4'hF
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    execute_if.slave  ex
);

    localparam logic [3:0] c_I_RRMOVQ = 4'h2;
    localparam logic [3:0] c_I_IRMOVQ = 4'h3;
    localparam logic [3:0] c_I_RMMOVQ = 4'h4;
    localparam logic [3:0] c_I_MRMOVQ = 4'h5;
    localparam logic [3:0] c_I_OPQ    = 4'h6;
    localparam logic [3:0] c_I_JXX    = 4'h7;
    localparam logic [3:0] c_I_CALL   = 4'h8;
    localparam logic [3:0] c_I_RET    = 4'h9;
    localparam logic [3:0] c_I_PUSHQ  = 4'hA;
    localparam logic [3:0] c_I_POPQ   = 4'hB;

    localparam logic [1:0] c_ALU_ADD  = 2'd0;
    localparam logic [1:0] c_ALU_SUB  = 2'd1;
    localparam logic [1:0] c_ALU_AND  = 2'd2;
    localparam logic [1:0] c_ALU_XOR  = 2'd3;

    localparam logic [2:0] c_CC_RESET = 3'b100;

    logic [3:0]  r_icode;
    logic        r_cnd;
    logic [63:0] r_valE;
    logic [63:0] r_valA;
    logic [3:0]  r_dstE;
    logic [3:0]  r_dstM;
    logic        r_valid;
    logic        r_imem_error;
    logic [2:0]  r_cc;

    logic [63:0] w_aluA;
    logic [63:0] w_aluB;
    logic [1:0]  w_aluop;
    logic        w_alu_bad;
    logic [63:0] w_valE;
    logic [2:0]  w_new_cc;
    logic        w_cond;
    logic        w_cond_bad;
    logic        w_cnd;
    logic        w_cnd_bad;
    logic [3:0]  w_dstE;
    logic        w_valid;
    logic        w_cc_we;

    wire logic w_zf = r_cc[2];
    wire logic w_sf = r_cc[1];
    wire logic w_of = r_cc[0];

    // ALU operand selection
    always_comb begin
        w_aluA = 64'd0;
        w_aluB = 64'd0;
        case (ex.icode_i)
            c_I_RRMOVQ, c_I_OPQ:                 w_aluA = ex.valA_i;
            c_I_IRMOVQ, c_I_RMMOVQ, c_I_MRMOVQ:  w_aluA = ex.valC_i;
            c_I_CALL, c_I_PUSHQ:                 w_aluA = 64'hFFFF_FFFF_FFFF_FFF8;
            c_I_RET, c_I_POPQ:                   w_aluA = 64'd8;
            default:                             w_aluA = 64'd0;
        endcase
        case (ex.icode_i)
            c_I_RMMOVQ, c_I_MRMOVQ, c_I_OPQ,
            c_I_CALL, c_I_RET, c_I_PUSHQ,
            c_I_POPQ:                            w_aluB = ex.valB_i;
            default:                             w_aluB = 64'd0;
        endcase
    end

    // ALU and new condition codes {ZF,SF,OF}
    always_comb begin
        w_aluop   = c_ALU_ADD;
        w_alu_bad = 1'b0;
        w_valE    = 64'd0;
        w_new_cc  = 3'b000;
        if (ex.icode_i == c_I_OPQ) begin
            w_aluop   = ex.ifun_i[1:0];
            w_alu_bad = (ex.ifun_i[3:2] != 2'b00);
        end
        if (!w_alu_bad) begin
            case (w_aluop)
                c_ALU_ADD: w_valE = w_aluB + w_aluA;
                c_ALU_SUB: w_valE = w_aluB - w_aluA;
                c_ALU_AND: w_valE = w_aluB & w_aluA;
                c_ALU_XOR: w_valE = w_aluB ^ w_aluA;
                default:   w_valE = 64'd0;
            endcase
        end
        w_new_cc[2] = (w_valE == 64'd0);
        w_new_cc[1] = w_valE[63];
        if (!w_alu_bad) begin
            case (w_aluop)
                c_ALU_ADD: w_new_cc[0] = (w_aluA[63] == w_aluB[63]) && (w_valE[63] != w_aluA[63]);
                c_ALU_SUB: w_new_cc[0] = (w_aluA[63] != w_aluB[63]) && (w_valE[63] != w_aluB[63]);
                default:   w_new_cc[0] = 1'b0;
            endcase
        end
    end

    // Branch/move condition, evaluated against the CC held before this instruction
    always_comb begin
        w_cond     = 1'b0;
        w_cond_bad = 1'b0;
        case (ex.ifun_i)
            4'h0:    w_cond = 1'b1;
            4'h1:    w_cond = (w_sf ^ w_of) | w_zf;
            4'h2:    w_cond = w_sf ^ w_of;
            4'h3:    w_cond = w_zf;
            4'h4:    w_cond = ~w_zf;
            4'h5:    w_cond = ~(w_sf ^ w_of);
            4'h6:    w_cond = ~(w_sf ^ w_of) & ~w_zf;
            default: w_cond_bad = 1'b1;
        endcase
    end

    always_comb begin
        w_cnd     = 1'b0;
        w_cnd_bad = 1'b0;
        w_dstE    = ex.dstE_i;
`ifdef EXEC_CMOV_EN
        if ((ex.icode_i == c_I_JXX) || (ex.icode_i == c_I_RRMOVQ)) begin
            w_cnd     = w_cond;
            w_cnd_bad = w_cond_bad;
        end
        if ((ex.icode_i == c_I_RRMOVQ) && !w_cnd) begin
            w_dstE = RNONE;
        end
`else
        if (ex.icode_i == c_I_JXX) begin
            w_cnd     = w_cond;
            w_cnd_bad = w_cond_bad;
        end else if (ex.icode_i == c_I_RRMOVQ) begin
            w_cnd = 1'b1;
        end
`endif
    end

    assign w_valid = ex.instr_valid_i & ~w_alu_bad & ~w_cnd_bad;

    assign w_cc_we = (ex.icode_i == c_I_OPQ) && ex.instr_valid_i && !ex.imem_error_i
                     && !ex.stall_i && !ex.bubble_i && !ex.squash_cc_i && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_icode      <= NOP_ICODE;
            r_cnd        <= 1'b0;
            r_valE       <= 64'd0;
            r_valA       <= 64'd0;
            r_dstE       <= RNONE;
            r_dstM       <= RNONE;
            r_valid      <= 1'b1;
            r_imem_error <= 1'b0;
            r_cc         <= c_CC_RESET;
        end else if (!ex.stall_i) begin
            if (ex.bubble_i) begin
                r_icode      <= NOP_ICODE;
                r_cnd        <= 1'b0;
                r_valE       <= 64'd0;
                r_valA       <= 64'd0;
                r_dstE       <= RNONE;
                r_dstM       <= RNONE;
                r_valid      <= 1'b1;
                r_imem_error <= 1'b0;
            end else begin
                r_icode      <= ex.icode_i;
                r_cnd        <= w_cnd;
                r_valE       <= w_valE;
                r_valA       <= ex.valA_i;
                r_dstE       <= w_dstE;
                r_dstM       <= ex.dstM_i;
                r_valid      <= w_valid;
                r_imem_error <= ex.imem_error_i;
            end
            if (w_cc_we) begin
                r_cc <= w_new_cc;
            end
        end
    end

    assign ex.icode_o       = r_icode;
    assign ex.cnd_o         = r_cnd;
    assign ex.valE_o        = r_valE;
    assign ex.valA_o        = r_valA;
    assign ex.dstE_o        = r_dstE;
    assign ex.dstM_o        = r_dstM;
    assign ex.instr_valid_o = r_valid;
    assign ex.imem_error_o  = r_imem_error;
    assign ex.cc_o          = r_cc;

endmodule

`default_nettype wire

// File: doc/execute_stage.md
# execute_stage

Execute stage of the Y86-64 CPU, directly downstream of `decode`. Takes decoded fields (`icode`, `ifun`, `valA`, `valB`, `valC`, destination IDs), computes `valE` in a 64-bit ALU, evaluates jump/cmov conditions against a 3-bit condition-code register, and updates CC on `OPq`. Results are latched into an E/M pipeline register with stall and bubble control; memory and write-back consume them.

## Interface
- `NOP_ICODE`, default 4'h1: icode inserted by bubble and reset.
- `RNONE`, default 4'hF: "no register" ID.
- `clk_i` in 1: clock, all state on rising edge.
- `rst_i` in 1: synchronous reset, active-high.
- `icode_i` in 4: instruction code from decode.
- `ifun_i` in 4: function code (ALU op or condition).
- `valA_i`, `valB_i` in 64: register operands from decode.
- `valC_i` in 64: constant word from fetch.
- `dstE_i`, `dstM_i` in 4: destination register IDs.
- `instr_valid_i` in 1: instruction legal.
- `imem_error_i` in 1: fetch address fault.
- `stall_i` in 1: hold pipeline register and CC.
- `bubble_i` in 1: load NOP into pipeline register.
- `squash_cc_i` in 1: block CC update this cycle (downstream exception).
- `icode_o` out 4, `cnd_o` out 1, `valE_o` out 64, `valA_o` out 64, `dstE_o` out 4, `dstM_o` out 4, `instr_valid_o` out 1, `imem_error_o` out 1: registered E/M fields.
- `cc_o` out 3: {ZF,SF,OF}, current CC register.

## Operation
- aluA: `valA_i` for icode 2,6; `valC_i` for 3,4,5; -8 for 8,A; +8 for 9,B; else 0.
- aluB: `valB_i` for 4,5,6,8,9,A,B; 0 for 2,3; else 0.
- ALU op = `ifun_i` when icode 6, else ADD. ADD 0: B+A; SUB 1: B-A; AND 2: B&A; XOR 3: B^A; ifun 4-F on OPq: valE=0, `instr_valid_o`=0.
- Arithmetic modulo 2^64, carry discarded.
- New CC: ZF=(valE==0); SF=valE[63]; OF for ADD = (A[63]==B[63])&&(E[63]!=A[63]); SUB = (A[63]!=B[63])&&(E[63]!=B[63]); AND/XOR OF=0.
- CC written iff icode==6 && instr_valid_i && !imem_error_i && !stall_i && !bubble_i && !squash_cc_i && !rst_i.
- cnd uses CC *before* this instruction's update: ifun 0 always; 1 le (SF^OF)|ZF; 2 l SF^OF; 3 e ZF; 4 ne !ZF; 5 ge !(SF^OF); 6 g !(SF^OF)&!ZF; 7-F cnd=0, valid forced 0. Evaluated for icode 2 and 7 only; other icodes cnd=0.
- cmov (icode 2, ifun≠0) with cnd=0: `dstE_o`=RNONE.
- valA, dstM, icode, valid, imem_error pass through unchanged.

## Timing
- Reset: icode_o=NOP_ICODE, cnd_o=0, valE_o=0, valA_o=0, dstE_o=dstM_o=RNONE, instr_valid_o=1, imem_error_o=0, cc_o=3'b100.
- Latency 1 cycle: inputs at edge N appear on outputs after edge N; cc_o updates same edge.
- stall_i: all outputs and CC hold. stall_i and bubble_i both high: stall wins.
- bubble_i (no stall): outputs load reset values except cc_o (holds).
- Reset mid-stall: reset wins.
- Back-to-back OPq: second sees CC written by first (no bypass needed, CC registered once per edge).

## Configuration
- `EXEC_CMOV_EN` defined: conditional moves as above.
- Not defined: icode 2 always has cnd_o=1, dstE_o=dstE_i regardless of ifun; ifun 7-F not flagged invalid for icode 2.

## Test plan
- Reset held 2 cycles -> icode_o=1, dstE_o=F, cc_o=3'b100, valE_o=0.
- OPq addq valA=0x7FFF_FFFF_FFFF_FFFF, valB=1 -> valE_o=0x8000_0000_0000_0000, cc_o=3'b011.
- OPq subq valA=5, valB=5, then jXX je (ifun 3) -> valE_o=0, cc_o=3'b100, next cycle cnd_o=1.
- cmovl (ifun 2) with CC=3'b100, dstE_i=3 -> cnd_o=0, dstE_o=F; without `EXEC_CMOV_EN` -> cnd_o=1, dstE_o=3.
- addq with stall_i=1 -> outputs and cc_o unchanged; squash_cc_i=1 on subq 1-2 -> valE_o=0xFFFF_FFFF_FFFF_FFFF, cc_o unchanged.
- pushq valB=0x100 -> valE_o=0xF8; bubble_i=1 next cycle -> icode_o=1, dstE_o=F, cc_o held.
